// File: rtl/ins_fetch_if.sv
// Fetch-to-memory-controller bus: one-cycle request pulse out,
// one-cycle instruction word response back.
interface ins_fetch_if;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_resp_valid,
        output mem_resp_data
    );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch: single-outstanding word fetch, in-order queue,
// static JAL prediction, flush redirect, one issue per cycle.
module ins_fetch #(
    parameter int IQ_DEPTH = 4,
    parameter int IQ_ADDR  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    ins_fetch_if.master mem,
    input  logic        dec_stall,
    output logic        if_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        if_pred_jump,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc
);
    localparam logic [IQ_ADDR:0] IQ_FULL = (IQ_ADDR + 1)'(IQ_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    state_t state, state_nx;

    logic [31:0] fetch_pc, fetch_pc_nx;
    logic        req_valid_q, req_valid_nx;
    logic [31:0] req_addr_q, req_addr_nx;

    logic [31:0] iq_instr [IQ_DEPTH];
    logic [31:0] iq_pc    [IQ_DEPTH];
    logic        iq_jal   [IQ_DEPTH];

    logic [IQ_ADDR-1:0] head, tail;
    logic [IQ_ADDR:0]   count;

    logic        push, pop, flush;
    logic        is_jal;
    logic [31:0] resp;
    logic [31:0] imm_j;

    assign resp   = mem.mem_resp_data;
    assign is_jal = (resp[6:0] == 7'b1101111);
    assign imm_j  = {{12{resp[31]}}, resp[19:12], resp[20], resp[30:21], 1'b0};

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_addr  = req_addr_q;

    // Next state, request, queue push/pop and next fetch PC
    always_comb begin
        state_nx     = state;
        fetch_pc_nx  = fetch_pc;
        req_valid_nx = 1'b0;
        req_addr_nx  = req_addr_q;
        push         = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        if (rob_clear) begin
            flush       = 1'b1;
            fetch_pc_nx = rob_new_pc;
            unique case (state)
                IDLE:    state_nx = IDLE;
                WAIT:    state_nx = mem.mem_resp_valid ? IDLE : DISCARD;
                DISCARD: state_nx = mem.mem_resp_valid ? IDLE : DISCARD;
                default: state_nx = IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    if (count < IQ_FULL) begin
                        req_valid_nx = 1'b1;
                        req_addr_nx  = fetch_pc;
                        state_nx     = WAIT;
                    end
                end
                WAIT: begin
                    if (mem.mem_resp_valid) begin
                        push        = 1'b1;
                        fetch_pc_nx = fetch_pc + (is_jal ? imm_j : 32'd4);
                        state_nx    = IDLE;
                    end
                end
                DISCARD: begin
                    if (mem.mem_resp_valid) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
            pop = (count != '0) && !dec_stall;
        end
    end

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (rst_in)      state <= IDLE;
        else if (rdy_in) state <= state_nx;
    end

    // Fetch PC, request outputs, queue pointers and decoder outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_pc     <= '0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            if_valid     <= 1'b0;
            instr        <= '0;
            pc           <= '0;
            if_pred_jump <= 1'b0;
        end else if (rdy_in) begin
            fetch_pc    <= fetch_pc_nx;
            req_valid_q <= req_valid_nx;
            req_addr_q  <= req_addr_nx;
            if (flush) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                if_valid <= 1'b0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop) begin
                    head         <= head + 1'b1;
                    if_valid     <= 1'b1;
                    instr        <= iq_instr[head];
                    pc           <= iq_pc[head];
                    if_pred_jump <= iq_jal[head];
                end else begin
                    if_valid <= 1'b0;
                end
                count <= count
                       + {{IQ_ADDR{1'b0}}, push}
                       - {{IQ_ADDR{1'b0}}, pop};
            end
        end
    end

    // Queue storage: write the returned word with its PC and JAL flag
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && push) begin
            iq_instr[tail] <= resp;
            iq_pc[tail]    <= fetch_pc;
            iq_jal[tail]   <= is_jal;
        end
    end
endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: memory model, program-order reference stream,
// directed scenarios and a randomized run.
`timescale 1ns/1ps
module tb_ins_fetch;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        dec_stall;
    logic        rob_clear;
    logic [31:0] rob_new_pc;
    logic        if_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        if_pred_jump;

    ins_fetch_if mem_bus();

    ins_fetch #(.IQ_DEPTH(4), .IQ_ADDR(2)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .mem(mem_bus.master),
        .dec_stall(dec_stall),
        .if_valid(if_valid),
        .instr(instr),
        .pc(pc),
        .if_pred_jump(if_pred_jump),
        .rob_clear(rob_clear),
        .rob_new_pc(rob_new_pc)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;
    int lat    = 1;

    function automatic logic [31:0] jal_word(input int imm);
        logic [31:0] i;
        i = imm;
        return {i[20], i[10:1], i[11], i[19:12], 5'd0, 7'b1101111};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0010_8113;
            32'h0000_0008: return 32'h0020_81B3;
            32'h0000_000C: return 32'h0000_0013;
            32'h0000_0010: return 32'h0100_006F;
            32'hFFFF_FFFC: return 32'h0000_0013;
            default: begin
                h = a * 32'h9E37_79B1;
                h = h ^ (h >> 13);
                if (h[2:0] == 3'd0)
                    return jal_word((int'(h[8:4]) - 16) * 4);
                return {h[31:7], 7'b0010011};
            end
        endcase
    endfunction

    function automatic logic [31:0] nxt(input logic [31:0] a,
                                        input logic [31:0] w);
        int imm;
        if (w[6:0] != 7'b1101111) return a + 32'd4;
        imm = (int'(w[30:21]) << 1) + (int'(w[20]) << 11)
            + (int'(w[19:12]) << 12) - (w[31] ? (1 << 20) : 0);
        return a + 32'(imm);
    endfunction

    // memory controller model and program-order reference checks
    logic        s_rst, s_rdy, s_clr, s_stall;
    logic [31:0] s_npc;
    logic        pend = 1'b0;
    logic [31:0] p_addr = '0;
    int          p_dly = 0;
    logic [31:0] exp_req = '0;
    logic [31:0] exp_iss = '0;
    logic [31:0] mw;

    always begin
        @(posedge clk_in);
        s_rst   = rst_in;
        s_rdy   = rdy_in;
        s_clr   = rob_clear;
        s_stall = dec_stall;
        s_npc   = rob_new_pc;
        #1;
        if (s_rst) begin
            pend = 1'b0;
            mem_bus.mem_resp_valid = 1'b0;
            exp_req = '0;
            exp_iss = '0;
        end else if (s_rdy) begin
            if (s_clr) begin
                exp_req = s_npc;
                exp_iss = s_npc;
            end
            mem_bus.mem_resp_valid = 1'b0;
            if (mem_bus.mem_req_valid) begin
                n_chk++;
                if (pend || mem_bus.mem_req_addr !== exp_req) begin
                    n_fail++;
                    $display("FAIL mon_req: addr %h outstanding %0b, expected addr %h outstanding 0",
                             mem_bus.mem_req_addr, pend, exp_req);
                end
                pend   = 1'b1;
                p_addr = mem_bus.mem_req_addr;
                p_dly  = (lat == 0) ? int'($urandom_range(0, 2)) : lat - 1;
                exp_req = nxt(p_addr, mem_word(p_addr));
            end
            if (pend) begin
                if (p_dly == 0) begin
                    mem_bus.mem_resp_valid = 1'b1;
                    mem_bus.mem_resp_data  = mem_word(p_addr);
                    pend = 1'b0;
                end else begin
                    p_dly--;
                end
            end
            if (if_valid) begin
                mw = mem_word(exp_iss);
                n_chk++;
                if (pc !== exp_iss || instr !== mw
                    || if_pred_jump !== (mw[6:0] == 7'b1101111)
                    || s_stall || s_clr) begin
                    n_fail++;
                    $display("FAIL mon_issue: pc %h instr %h jump %0b stall %0b clr %0b, expected pc %h instr %h jump %0b stall 0 clr 0",
                             pc, instr, if_pred_jump, s_stall, s_clr,
                             exp_iss, mw, mw[6:0] == 7'b1101111);
                end
                exp_iss = nxt(exp_iss, mw);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_lat(input int v);
        @(negedge clk_in);
        lat = v;
    endtask

    task automatic do_reset();
        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        dec_stall = 1'b0;
        rob_clear = 1'b0;
        rob_new_pc = '0;
        step();
        step();
        rst_in = 1'b0;
    endtask

    task automatic wait_req(input int bound, output logic ok,
                            output logic [31:0] a);
        ok = 1'b0;
        a  = '0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (mem_bus.mem_req_valid) begin
                ok = 1'b1;
                a  = mem_bus.mem_req_addr;
                return;
            end
        end
    endtask

    task automatic test_reset();
        lat = 1;
        do_reset();
        n_chk++;
        if ({mem_bus.mem_req_valid, mem_bus.mem_req_addr, if_valid,
             instr, pc, if_pred_jump} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: req %0b addr %h v %0b instr %h pc %h j %0b, expected all 0",
                     mem_bus.mem_req_valid, mem_bus.mem_req_addr,
                     if_valid, instr, pc, if_pred_jump);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_w [3];
        logic        got_req;
        logic [31:0] first_req;
        int          k;
        exp_w[0] = 32'h0050_0093;
        exp_w[1] = 32'h0010_8113;
        exp_w[2] = 32'h0020_81B3;
        got_req = 1'b0;
        first_req = 32'hDEAD_BEEF;
        k = 0;
        lat = 1;
        do_reset();
        for (int c = 0; c < 40 && k < 3; c++) begin
            step();
            if (mem_bus.mem_req_valid && !got_req) begin
                got_req = 1'b1;
                first_req = mem_bus.mem_req_addr;
            end
            if (if_valid) begin
                n_chk++;
                if (pc !== 32'(4 * k) || instr !== exp_w[k]) begin
                    n_fail++;
                    $display("FAIL seq_issue%0d: pc %h instr %h, expected pc %h instr %h",
                             k, pc, instr, 32'(4 * k), exp_w[k]);
                end
                k++;
            end
        end
        n_chk++;
        if (k != 3 || first_req !== 32'h0) begin
            n_fail++;
            $display("FAIL seq_count: issues %0d first_req %h, expected 3 and 00000000",
                     k, first_req);
        end
    endtask

    task automatic test_jal();
        logic [31:0] reqs[$];
        logic        seen;
        logic        flag;
        logic        ok;
        seen = 1'b0;
        flag = 1'b0;
        ok   = 1'b0;
        lat  = 1;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            step();
            if (mem_bus.mem_req_valid) reqs.push_back(mem_bus.mem_req_addr);
            if (if_valid && pc == 32'h10 && !seen) begin
                seen = 1'b1;
                flag = if_pred_jump;
            end
        end
        n_chk++;
        if (!seen || flag !== 1'b1) begin
            n_fail++;
            $display("FAIL jal_flag: seen %0b jump %0b, expected seen 1 jump 1",
                     seen, flag);
        end
        for (int i = 0; i + 1 < reqs.size(); i++)
            if (reqs[i] == 32'h10 && reqs[i+1] == 32'h20) ok = 1'b1;
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL jal_target: request after 00000010 not 00000020 (%0d requests), expected 00000020",
                     reqs.size());
        end
    endtask

    task automatic test_stall();
        int          nreq;
        int          niss;
        logic        got;
        logic [31:0] resume;
        nreq = 0;
        niss = 0;
        got  = 1'b0;
        resume = 32'hDEAD_BEEF;
        lat  = 1;
        do_reset();
        dec_stall = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (mem_bus.mem_req_valid) nreq++;
            if (if_valid) niss++;
        end
        n_chk++;
        if (nreq != 4 || niss != 0 || mem_bus.mem_req_valid !== 1'b0
            || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_full: requests %0d issues %0d req %0b v %0b, expected 4 0 0 0",
                     nreq, niss, mem_bus.mem_req_valid, if_valid);
        end
        dec_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_bus.mem_req_valid && !got) begin
                got = 1'b1;
                resume = mem_bus.mem_req_addr;
            end
            n_chk++;
            if (if_valid !== 1'b1 || pc !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL stall_drain%0d: v %0b pc %h, expected v 1 pc %h",
                         i, if_valid, pc, 32'(4 * i));
            end
        end
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (mem_bus.mem_req_valid) begin
                got = 1'b1;
                resume = mem_bus.mem_req_addr;
            end
        end
        n_chk++;
        if (resume !== 32'h10) begin
            n_fail++;
            $display("FAIL stall_resume: req %h, expected 00000010", resume);
        end
    endtask

    task automatic post_flush(input string nm, input logic [31:0] tgt);
        logic [31:0] fr;
        logic [31:0] fi;
        logic        gr;
        logic        gi;
        fr = 32'hDEAD_BEEF;
        fi = 32'hDEAD_BEEF;
        gr = 1'b0;
        gi = 1'b0;
        for (int c = 0; c < 40 && !(gr && gi); c++) begin
            step();
            if (mem_bus.mem_req_valid && !gr) begin
                gr = 1'b1;
                fr = mem_bus.mem_req_addr;
            end
            if (if_valid && !gi) begin
                gi = 1'b1;
                fi = pc;
            end
        end
        n_chk++;
        if (fr !== tgt || fi !== tgt) begin
            n_fail++;
            $display("FAIL %s: first req %h first issue %h, expected %h %h",
                     nm, fr, fi, tgt, tgt);
        end
    endtask

    task automatic test_flush_wait();
        logic        ok;
        logic [31:0] a;
        lat = 1;
        do_reset();
        dec_stall = 1'b1;
        wait_req(10, ok, a);
        wait_req(10, ok, a);
        set_lat(3);
        wait_req(10, ok, a);
        n_chk++;
        if (!ok || a !== 32'h8) begin
            n_fail++;
            $display("FAIL fw_setup: ok %0b req %h, expected 1 00000008", ok, a);
        end
        rob_clear  = 1'b1;
        rob_new_pc = 32'h100;
        step();
        rob_clear = 1'b0;
        dec_stall = 1'b0;
        n_chk++;
        if (if_valid !== 1'b0 || mem_bus.mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fw_flush: v %0b req %0b, expected 0 0",
                     if_valid, mem_bus.mem_req_valid);
        end
        post_flush("fw_redirect", 32'h100);
        set_lat(1);
    endtask

    task automatic test_flush_resp();
        logic        ok;
        logic [31:0] a;
        lat = 1;
        do_reset();
        wait_req(10, ok, a);
        rob_clear  = 1'b1;
        rob_new_pc = 32'h180;
        set_lat(4);
        step();
        rob_clear = 1'b0;
        n_chk++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fr_drop: v %0b, expected 0", if_valid);
        end
        wait_req(10, ok, a);
        n_chk++;
        if (!ok || a !== 32'h180) begin
            n_fail++;
            $display("FAIL fr_redirect: ok %0b req %h, expected 1 00000180", ok, a);
        end
        rob_clear  = 1'b1;
        rob_new_pc = 32'h1C0;
        step();
        rob_new_pc = 32'h200;
        step();
        rob_clear = 1'b0;
        n_chk++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fr_discard: v %0b, expected 0", if_valid);
        end
        set_lat(1);
        post_flush("fr_second", 32'h200);
    endtask

    task automatic test_freeze();
        logic        ok;
        logic [31:0] a;
        logic [98:0] snap;
        lat = 1;
        do_reset();
        dec_stall = 1'b1;
        wait_req(10, ok, a);
        wait_req(10, ok, a);
        set_lat(5);
        wait_req(10, ok, a);
        snap = {mem_bus.mem_req_valid, mem_bus.mem_req_addr, if_valid,
                instr, pc, if_pred_jump};
        rdy_in    = 1'b0;
        dec_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if ({mem_bus.mem_req_valid, mem_bus.mem_req_addr, if_valid,
                 instr, pc, if_pred_jump} !== snap) begin
                n_fail++;
                $display("FAIL freeze%0d: outputs %h, expected %h", i,
                         {mem_bus.mem_req_valid, mem_bus.mem_req_addr,
                          if_valid, instr, pc, if_pred_jump}, snap);
            end
        end
        rdy_in = 1'b1;
        step();
        n_chk++;
        if (if_valid !== 1'b1 || pc !== 32'h0 || mem_bus.mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL thaw: v %0b pc %h req %0b, expected 1 00000000 0",
                     if_valid, pc, mem_bus.mem_req_valid);
        end
        set_lat(1);
    endtask

    task automatic test_wrap();
        logic        ok0;
        logic        ok1;
        logic [31:0] a0;
        logic [31:0] a1;
        lat = 1;
        do_reset();
        rob_clear  = 1'b1;
        rob_new_pc = 32'hFFFF_FFFC;
        step();
        rob_clear = 1'b0;
        wait_req(10, ok0, a0);
        wait_req(10, ok1, a1);
        n_chk++;
        if (!ok0 || !ok1 || a0 !== 32'hFFFF_FFFC || a1 !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap: reqs %h %h, expected fffffffc 00000000", a0, a1);
        end
    endtask

    task automatic test_rst_mid();
        logic        ok;
        logic [31:0] a;
        lat = 1;
        do_reset();
        wait_req(10, ok, a);
        wait_req(10, ok, a);
        wait_req(10, ok, a);
        rst_in = 1'b1;
        step();
        n_chk++;
        if ({mem_bus.mem_req_valid, mem_bus.mem_req_addr, if_valid,
             instr, pc, if_pred_jump} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: req %0b addr %h v %0b instr %h pc %h j %0b, expected all 0",
                     mem_bus.mem_req_valid, mem_bus.mem_req_addr,
                     if_valid, instr, pc, if_pred_jump);
        end
        rst_in = 1'b0;
        wait_req(10, ok, a);
        n_chk++;
        if (!ok || a !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_refetch: ok %0b req %h, expected 1 00000000", ok, a);
        end
    endtask

    task automatic test_random();
        int niss;
        niss = 0;
        lat  = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            dec_stall  = ($urandom_range(0, 2) == 0);
            rdy_in     = ($urandom_range(0, 15) != 0);
            rob_clear  = ($urandom_range(0, 40) == 0);
            rob_new_pc = $urandom & 32'hFFFF_FFFC;
            step();
            if (if_valid) niss++;
        end
        dec_stall = 1'b0;
        rdy_in    = 1'b1;
        rob_clear = 1'b0;
        for (int c = 0; c < 20; c++) step();
        n_chk++;
        if (niss < 100) begin
            n_fail++;
            $display("FAIL random_progress: issues %0d, expected at least 100", niss);
        end
    endtask

    initial begin
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_data  = '0;
        rst_in     = 1'b1;
        rdy_in     = 1'b1;
        dec_stall  = 1'b0;
        rob_clear  = 1'b0;
        rob_new_pc = '0;
        test_reset();
        test_sequential();
        test_jal();
        test_stall();
        test_flush_wait();
        test_flush_resp();
        test_freeze();
        test_wrap();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
